// File: rtl/mac_chan_pkg.sv
// mac_chan_pkg: shared types, default parameters and sizing helper for the
// multi-channel MAC bridge (mac_chan_bridge and mac_tag_fifo).
package mac_chan_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DEPTH  = 8;

    // Tag width for a channel count; never narrower than one bit.
    function automatic int tag_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    localparam int TAG_W = tag_width(DEF_NUM_CH);

    // Operand bundle handed to the core at the default operand width.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
        logic                 mode;
        logic                 cfg;
    } op_t;

    // Result bundle returned by the core at the default operand width.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] c;
        logic                 err;
    } rsp_t;

endpackage

// File: rtl/mac_tag_fifo.sv
// mac_tag_fifo: synchronous in-order FIFO holding the originating channel of
// every op currently inside the MAC core. Pointers carry one extra wrap bit so
// that full and empty are distinguishable at equal slot indices.
module mac_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Pointer registers; push and pop advance independently.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Tag storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; occupancy is defined only by the pointers.
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;

endmodule

// File: rtl/mac_chan_bridge.sv
// mac_chan_bridge: round-robin front end that funnels NUM_CH operand channels
// onto the single MAC core port and steers in-order core results back to the
// channel that issued each op.
// Optional build macro: MAC_CHAN_BRIDGE_ERRCNT_EN adds per-channel saturating
// 8-bit error counters on output err_cnt.
module mac_chan_bridge
    import mac_chan_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ch_vld,
    output logic [NUM_CH-1:0]          ch_rdy,
    input  logic [NUM_CH*WIDTH-1:0]    ch_a,
    input  logic [NUM_CH*WIDTH-1:0]    ch_b,
    input  logic [NUM_CH-1:0]          ch_mode,
    input  logic                       cfg,
    output logic                       core_vld,
    input  logic                       core_rdy,
    output logic [WIDTH-1:0]           core_a,
    output logic [WIDTH-1:0]           core_b,
    output logic                       core_mode,
    output logic                       core_cfg,
    input  logic                       core_rvld,
    input  logic [WIDTH-1:0]           core_c,
    input  logic                       core_err,
    output logic [NUM_CH-1:0]          rsp_vld,
    output logic [WIDTH-1:0]           rsp_c,
    output logic                       rsp_err,
    output logic                       orphan,
    output logic [$clog2(DEPTH+1)-1:0] inflight
`ifdef MAC_CHAN_BRIDGE_ERRCNT_EN
    ,
    output logic [NUM_CH*8-1:0]        err_cnt
`endif
);

    localparam int TW = tag_width(NUM_CH);

    // Operand bundle at this instance's operand width.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             mode;
        logic             cfg;
    } chan_op_t;

    logic [TW-1:0]     rr_ptr;
    logic [TW-1:0]     grant_idx;
    logic              any_req;
    logic [NUM_CH-1:0] grant;
    logic              can_issue;
    logic              xfer;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [TW-1:0]     pop_tag;
    chan_op_t          core_op;
    chan_op_t          sel_op;

    // A result retires a tag only when one is outstanding; otherwise it is an orphan.
    assign pop = core_rvld && !fifo_empty;

    // The operand register is free when empty or being drained, and a tag slot exists or frees up now.
    assign can_issue = !rst && (!core_vld || core_rdy) && (!fifo_full || pop);

    // Round-robin search: first requesting channel at or after rr_ptr, wrapping.
    always_comb begin
        // NOTE: defaults first so no path through the search leaves a signal unassigned (no latch).
        any_req   = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!any_req && ch_vld[(int'(rr_ptr) + k) % NUM_CH]) begin
                any_req   = 1'b1;
                grant_idx = TW'((int'(rr_ptr) + k) % NUM_CH);
            end
        end
        grant = any_req ? (NUM_CH'(1) << grant_idx) : '0;
    end

    assign ch_rdy = can_issue ? grant : '0;
    assign xfer   = |ch_rdy;

    // Operand fields of the granted channel.
    always_comb begin
        sel_op.a    = ch_a[int'(grant_idx)*WIDTH +: WIDTH];
        sel_op.b    = ch_b[int'(grant_idx)*WIDTH +: WIDTH];
        sel_op.mode = ch_mode[grant_idx];
        sel_op.cfg  = cfg;
    end

    // Core operand register, valid flag and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_vld <= 1'b0;
            core_op  <= '0;
            rr_ptr   <= '0;
        end else if (xfer) begin
            core_vld <= 1'b1;
            core_op  <= sel_op;
            rr_ptr   <= (grant_idx == TW'(NUM_CH - 1)) ? '0 : grant_idx + TW'(1);
        end else if (core_rdy) begin
            core_vld <= 1'b0;
        end
    end

    assign core_a    = core_op.a;
    assign core_b    = core_op.b;
    assign core_mode = core_op.mode;
    assign core_cfg  = core_op.cfg;

    mac_tag_fifo #(
        .W     (TW),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (xfer),
        .push_data (grant_idx),
        .pop       (pop),
        .pop_data  (pop_tag),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (inflight)
    );

    // Response steering: one-cycle pulse to the owning channel; data holds between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld <= '0;
            rsp_c   <= '0;
            rsp_err <= 1'b0;
            orphan  <= 1'b0;
        end else begin
            rsp_vld <= pop ? (NUM_CH'(1) << pop_tag) : '0;
            if (pop) begin
                rsp_c   <= core_c;
                rsp_err <= core_err;
            end
            if (core_rvld && fifo_empty) orphan <= 1'b1;
        end
    end

`ifdef MAC_CHAN_BRIDGE_ERRCNT_EN
    // Per-channel saturating count of error responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (rsp_vld[i] && rsp_err && (err_cnt[i*8 +: 8] != 8'hFF))
                    err_cnt[i*8 +: 8] <= err_cnt[i*8 +: 8] + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mac_chan_bridge.sv
// tb_mac_chan_bridge: directed bench for mac_chan_bridge (WIDTH=16, NUM_CH=4,
// DEPTH=8). Inputs change 1 ns after the rising edge; outputs are read there.
// Define MAC_CHAN_BRIDGE_ERRCNT_EN to also exercise the error counters.
module tb_mac_chan_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ch_vld;
    logic [3:0]  ch_rdy;
    logic [63:0] ch_a;
    logic [63:0] ch_b;
    logic [3:0]  ch_mode;
    logic        cfg;
    logic        core_vld;
    logic        core_rdy;
    logic [15:0] core_a;
    logic [15:0] core_b;
    logic        core_mode;
    logic        core_cfg;
    logic        core_rvld;
    logic [15:0] core_c;
    logic        core_err;
    logic [3:0]  rsp_vld;
    logic [15:0] rsp_c;
    logic        rsp_err;
    logic        orphan;
    logic [3:0]  inflight;
`ifdef MAC_CHAN_BRIDGE_ERRCNT_EN
    logic [31:0] err_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac_chan_bridge #(
        .WIDTH  (16),
        .NUM_CH (4),
        .DEPTH  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_vld    (ch_vld),
        .ch_rdy    (ch_rdy),
        .ch_a      (ch_a),
        .ch_b      (ch_b),
        .ch_mode   (ch_mode),
        .cfg       (cfg),
        .core_vld  (core_vld),
        .core_rdy  (core_rdy),
        .core_a    (core_a),
        .core_b    (core_b),
        .core_mode (core_mode),
        .core_cfg  (core_cfg),
        .core_rvld (core_rvld),
        .core_c    (core_c),
        .core_err  (core_err),
        .rsp_vld   (rsp_vld),
        .rsp_c     (rsp_c),
        .rsp_err   (rsp_err),
        .orphan    (orphan),
        .inflight  (inflight)
`ifdef MAC_CHAN_BRIDGE_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [15:0] a, input logic [15:0] b, input logic m);
        ch_a[i*16 +: 16] = a;
        ch_b[i*16 +: 16] = b;
        ch_mode[i]       = m;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        ch_vld    = '0;
        ch_a      = '0;
        ch_b      = '0;
        ch_mode   = '0;
        cfg       = 1'b0;
        core_rdy  = 1'b0;
        core_rvld = 1'b0;
        core_c    = '0;
        core_err  = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        rst    = 1'b1;
        ch_vld = 4'hF;
        step();
        checks++; if (ch_rdy !== 4'b0000) begin failures++; $display("FAIL reset_ch_rdy: got %b expected 0000", ch_rdy); end
        checks++; if (core_vld !== 1'b0) begin failures++; $display("FAIL reset_core_vld: got %b expected 0", core_vld); end
        checks++; if ({core_a, core_b, core_mode, core_cfg} !== 34'd0) begin failures++; $display("FAIL reset_core_data: got a=%h b=%h expected 0", core_a, core_b); end
        checks++; if ({rsp_vld, rsp_c, rsp_err, orphan} !== 22'd0) begin failures++; $display("FAIL reset_rsp: got vld=%b c=%h err=%b orphan=%b expected 0", rsp_vld, rsp_c, rsp_err, orphan); end
        checks++; if (inflight !== 4'd0) begin failures++; $display("FAIL reset_inflight: got %0d expected 0", inflight); end
        rst    = 1'b0;
        ch_vld = '0;
    endtask

    task automatic test_single_op();
        do_reset();
        set_ch(2, 16'h0003, 16'h0004, 1'b0);
        cfg      = 1'b1;
        ch_vld   = 4'b0100;
        core_rdy = 1'b1;
        #1;
        checks++; if (ch_rdy !== 4'b0100) begin failures++; $display("FAIL single_grant: got %b expected 0100", ch_rdy); end
        step();
        ch_vld = '0;
        checks++; if (core_vld !== 1'b1) begin failures++; $display("FAIL single_core_vld: got %b expected 1", core_vld); end
        checks++; if (core_a !== 16'h0003 || core_b !== 16'h0004) begin failures++; $display("FAIL single_core_ab: got %h/%h expected 0003/0004", core_a, core_b); end
        checks++; if (core_mode !== 1'b0 || core_cfg !== 1'b1) begin failures++; $display("FAIL single_mode_cfg: got %b/%b expected 0/1", core_mode, core_cfg); end
        checks++; if (inflight !== 4'd1) begin failures++; $display("FAIL single_inflight: got %0d expected 1", inflight); end
        step();
        checks++; if (core_vld !== 1'b0) begin failures++; $display("FAIL single_vld_drop: got %b expected 0", core_vld); end
        core_rvld = 1'b1;
        core_c    = 16'h000C;
        step();
        core_rvld = 1'b0;
        core_c    = 16'hFFFF;
        checks++; if (rsp_vld !== 4'b0100) begin failures++; $display("FAIL single_rsp_vld: got %b expected 0100", rsp_vld); end
        checks++; if (rsp_c !== 16'h000C || rsp_err !== 1'b0) begin failures++; $display("FAIL single_rsp_c: got %h/%b expected 000c/0", rsp_c, rsp_err); end
        checks++; if (inflight !== 4'd0) begin failures++; $display("FAIL single_inflight_end: got %0d expected 0", inflight); end
        step();
        checks++; if (rsp_vld !== 4'b0000 || rsp_c !== 16'h000C) begin failures++; $display("FAIL single_rsp_hold: got %b/%h expected 0000/000c", rsp_vld, rsp_c); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_rdy;
        do_reset();
        for (int i = 0; i < 4; i++) set_ch(i, 16'h0010 + 16'(i), 16'h0020 + 16'(i), 1'b0);
        core_rdy = 1'b1;
        for (int n = 0; n < 15; n++) begin
            ch_vld    = (n < 12) ? 4'hF : 4'h0;
            core_rvld = (n >= 3);
            core_c    = 16'hC000 + 16'((n - 3) % 4);
            #1;
            exp_rdy = (n < 12) ? (4'b0001 << (n % 4)) : 4'b0000;
            checks++; if (ch_rdy !== exp_rdy) begin failures++; $display("FAIL rr_grant[%0d]: got %b expected %b", n, ch_rdy, exp_rdy); end
            step();
            if (n < 12) begin
                checks++; if (core_vld !== 1'b1 || core_a !== 16'h0010 + 16'(n % 4)) begin failures++; $display("FAIL rr_core_a[%0d]: got vld=%b a=%h expected 1/%h", n, core_vld, core_a, 16'h0010 + 16'(n % 4)); end
            end
            if (n >= 3) begin
                checks++; if (rsp_vld !== (4'b0001 << ((n - 3) % 4)) || rsp_c !== 16'hC000 + 16'((n - 3) % 4)) begin failures++; $display("FAIL rr_rsp[%0d]: got %b/%h expected %b/%h", n, rsp_vld, rsp_c, 4'b0001 << ((n - 3) % 4), 16'hC000 + 16'((n - 3) % 4)); end
            end
        end
        core_rvld = 1'b0;
        step();
        checks++; if (inflight !== 4'd0 || rsp_vld !== 4'b0000) begin failures++; $display("FAIL rr_drain: got inflight=%0d rsp_vld=%b expected 0/0000", inflight, rsp_vld); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) set_ch(i, 16'h0A00 + 16'(i), 16'h0B00, 1'b1);
        core_rdy = 1'b1;
        ch_vld   = 4'hF;
        for (int n = 0; n < 8; n++) step();
        checks++; if (inflight !== 4'd8) begin failures++; $display("FAIL full_inflight: got %0d expected 8", inflight); end
        checks++; if (ch_rdy !== 4'b0000) begin failures++; $display("FAIL full_no_grant: got %b expected 0000", ch_rdy); end
        core_rvld = 1'b1;
        core_c    = 16'h1234;
        #1;
        checks++; if (ch_rdy !== 4'b0001) begin failures++; $display("FAIL full_pop_grant: got %b expected 0001", ch_rdy); end
        step();
        core_rvld = 1'b0;
        #1;
        checks++; if (inflight !== 4'd8) begin failures++; $display("FAIL full_pushpop_inflight: got %0d expected 8", inflight); end
        checks++; if (rsp_vld !== 4'b0001 || rsp_c !== 16'h1234) begin failures++; $display("FAIL full_rsp: got %b/%h expected 0001/1234", rsp_vld, rsp_c); end
        checks++; if (core_a !== 16'h0A00 || core_mode !== 1'b1) begin failures++; $display("FAIL full_core_a: got %h/%b expected 0a00/1", core_a, core_mode); end
        checks++; if (ch_rdy !== 4'b0000) begin failures++; $display("FAIL full_regrant: got %b expected 0000", ch_rdy); end
        step();
        checks++; if (inflight !== 4'd8) begin failures++; $display("FAIL full_hold: got %0d expected 8", inflight); end
    endtask

    task automatic test_stall();
        do_reset();
        set_ch(1, 16'h1111, 16'h2222, 1'b0);
        ch_vld   = 4'b0010;
        core_rdy = 1'b0;
        #1;
        checks++; if (ch_rdy !== 4'b0010) begin failures++; $display("FAIL stall_first_grant: got %b expected 0010", ch_rdy); end
        step();
        set_ch(1, 16'h5555, 16'h6666, 1'b0);
        for (int n = 0; n < 5; n++) begin
            #1;
            checks++; if (ch_rdy !== 4'b0000) begin failures++; $display("FAIL stall_rdy[%0d]: got %b expected 0000", n, ch_rdy); end
            step();
            checks++; if (core_vld !== 1'b1 || core_a !== 16'h1111 || core_b !== 16'h2222) begin failures++; $display("FAIL stall_hold[%0d]: got %b %h/%h expected 1 1111/2222", n, core_vld, core_a, core_b); end
        end
        core_rdy = 1'b1;
        #1;
        checks++; if (ch_rdy !== 4'b0010) begin failures++; $display("FAIL stall_resume_grant: got %b expected 0010", ch_rdy); end
        step();
        ch_vld = '0;
        checks++; if (core_a !== 16'h5555 || core_b !== 16'h6666 || inflight !== 4'd2) begin failures++; $display("FAIL stall_resume: got %h/%h inflight=%0d expected 5555/6666 2", core_a, core_b, inflight); end
    endtask

    task automatic test_orphan_reset();
        do_reset();
        core_rvld = 1'b1;
        core_c    = 16'hBEEF;
        step();
        core_rvld = 1'b0;
        checks++; if (rsp_vld !== 4'b0000 || rsp_c !== 16'h0000) begin failures++; $display("FAIL orphan_drop: got %b/%h expected 0000/0000", rsp_vld, rsp_c); end
        checks++; if (orphan !== 1'b1) begin failures++; $display("FAIL orphan_set: got %b expected 1", orphan); end
        step();
        checks++; if (orphan !== 1'b1) begin failures++; $display("FAIL orphan_sticky: got %b expected 1", orphan); end
        ch_vld   = 4'hF;
        core_rdy = 1'b1;
        for (int n = 0; n < 3; n++) step();
        ch_vld = '0;
        #1;
        checks++; if (inflight !== 4'd3) begin failures++; $display("FAIL rst_pre_inflight: got %0d expected 3", inflight); end
        rst    = 1'b1;
        ch_vld = 4'hF;
        step();
        checks++; if (inflight !== 4'd0 || orphan !== 1'b0 || core_vld !== 1'b0) begin failures++; $display("FAIL rst_mid: got inflight=%0d orphan=%b vld=%b expected 0/0/0", inflight, orphan, core_vld); end
        checks++; if (ch_rdy !== 4'b0000 || core_a !== 16'h0000 || rsp_vld !== 4'b0000) begin failures++; $display("FAIL rst_mid_outputs: got rdy=%b a=%h rsp=%b expected 0", ch_rdy, core_a, rsp_vld); end
        rst       = 1'b0;
        ch_vld    = '0;
        core_rvld = 1'b1;
        step();
        core_rvld = 1'b0;
        checks++; if (orphan !== 1'b1 || rsp_vld !== 4'b0000) begin failures++; $display("FAIL rst_late_result: got orphan=%b rsp=%b expected 1/0000", orphan, rsp_vld); end
    endtask

`ifdef MAC_CHAN_BRIDGE_ERRCNT_EN
    task automatic test_err_cnt();
        do_reset();
        set_ch(3, 16'h0001, 16'h0001, 1'b0);
        core_rdy = 1'b1;
        core_err = 1'b1;
        for (int n = 0; n <= 300; n++) begin
            ch_vld    = (n < 300) ? 4'b1000 : 4'b0000;
            core_rvld = (n >= 1);
            step();
        end
        core_rvld = 1'b0;
        core_err  = 1'b0;
        step();
        step();
        checks++; if (err_cnt[31:24] !== 8'd255) begin failures++; $display("FAIL errcnt_sat: got %0d expected 255", err_cnt[31:24]); end
        checks++; if (err_cnt[23:0] !== 24'd0) begin failures++; $display("FAIL errcnt_others: got %h expected 000000", err_cnt[23:0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_op();
        test_fairness();
        test_full();
        test_stall();
        test_orphan_reset();
`ifdef MAC_CHAN_BRIDGE_ERRCNT_EN
        test_err_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
